// File: rtl/io_port_bridge.sv
// Word-level I/O bridge: host->processor input FIFO and processor->host output FIFO,
// each a DEPTH-entry circular buffer with valid/ready on the host side.
module io_port_bridge #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [WIDTH-1:0] read_in,
  output logic             in_avail,
  input  logic             in_ack,
  input  logic [WIDTH-1:0] write_out,
  input  logic             out_strobe,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic             out_overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Input FIFO state
  logic [WIDTH-1:0] r_in_mem [DEPTH];
  logic [AW-1:0]    r_in_rptr;
  logic [AW-1:0]    r_in_wptr;
  logic [CW-1:0]    r_in_cnt;
  logic             w_in_push;
  logic             w_in_pop;

  // Output FIFO state
  logic [WIDTH-1:0] r_out_mem [DEPTH];
  logic [AW-1:0]    r_out_rptr;
  logic [AW-1:0]    r_out_wptr;
  logic [CW-1:0]    r_out_cnt;
  logic             r_out_ovf;
  logic             w_out_push;
  logic             w_out_pop;
  logic             w_out_full;

  // Ready is gated by rst so the host sees no acceptance while reset is held.
  assign host_in_ready = rst && (r_in_cnt != FULL);
  assign in_avail      = (r_in_cnt != '0);
  assign w_in_push     = host_in_valid && host_in_ready;
  assign w_in_pop      = in_ack && in_avail;
  assign read_in       = in_avail ? r_in_mem[r_in_rptr] : '0;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_in_rptr <= '0;
      r_in_wptr <= '0;
      r_in_cnt  <= '0;
    end else begin
      if (w_in_push) r_in_wptr <= r_in_wptr + AW'(1);
      if (w_in_pop)  r_in_rptr <= r_in_rptr + AW'(1);
      if (w_in_push && !w_in_pop) begin
        r_in_cnt <= r_in_cnt + CW'(1);
      end else if (!w_in_push && w_in_pop) begin
        r_in_cnt <= r_in_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_in_push) r_in_mem[r_in_wptr] <= host_in_data;
  end

  assign host_out_valid = (r_out_cnt != '0);
  assign host_out_data  = host_out_valid ? r_out_mem[r_out_rptr] : '0;
  assign out_overflow   = r_out_ovf;
  assign w_out_full     = (r_out_cnt == FULL);
  assign w_out_pop      = host_out_valid && host_out_ready;
  // A strobe into a full FIFO still lands if the head leaves in the same cycle.
  assign w_out_push     = out_strobe && (!w_out_full || w_out_pop);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_out_rptr <= '0;
      r_out_wptr <= '0;
      r_out_cnt  <= '0;
      r_out_ovf  <= 1'b0;
    end else begin
      if (w_out_push) r_out_wptr <= r_out_wptr + AW'(1);
      if (w_out_pop)  r_out_rptr <= r_out_rptr + AW'(1);
      if (w_out_push && !w_out_pop) begin
        r_out_cnt <= r_out_cnt + CW'(1);
      end else if (!w_out_push && w_out_pop) begin
        r_out_cnt <= r_out_cnt - CW'(1);
      end
      if (out_strobe && w_out_full && !w_out_pop) r_out_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_out_push) r_out_mem[r_out_wptr] <= write_out;
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: vector table for the input FIFO, scoreboard queue for the
// output FIFO, and hand-written sequences for overflow, full-with-pop and mid-run reset.
module tb_io_port_bridge;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 16;

  logic             clock = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] host_in_data = '0;
  logic             host_in_valid = 1'b0;
  logic             host_in_ready;
  logic [WIDTH-1:0] read_in;
  logic             in_avail;
  logic             in_ack = 1'b0;
  logic [WIDTH-1:0] write_out = '0;
  logic             out_strobe = 1'b0;
  logic [WIDTH-1:0] host_out_data;
  logic             host_out_valid;
  logic             host_out_ready = 1'b0;
  logic             out_overflow;

  io_port_bridge #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clock          (clock),
    .rst            (rst),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .read_in        (read_in),
    .in_avail       (in_avail),
    .in_ack         (in_ack),
    .write_out      (write_out),
    .out_strobe     (out_strobe),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .out_overflow   (out_overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] sb_q[$];

  typedef struct {
    logic             hv;
    logic [WIDTH-1:0] hd;
    logic             ack;
    logic             e_rdy;
    logic             e_av;
    logic [WIDTH-1:0] e_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Host drains the output FIFO, comparing every accepted word against the scoreboard.
  task automatic drain(input int limit);
    logic [WIDTH-1:0] exp;
    host_out_ready = 1'b1;
    for (int c = 0; c < limit && sb_q.size() != 0; c++) begin
      if (host_out_valid) begin
        exp = sb_q.pop_front();
        check("out_data", 32'(host_out_data), 32'(exp));
      end
      tick();
    end
    check("drain_left", 32'(sb_q.size()), 32'd0);
    host_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h1111};
    vecs[1]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 16'h1111};
    vecs[2]  = '{1'b1, 16'h3333, 1'b0, 1'b1, 1'b1, 16'h1111};
    vecs[3]  = '{1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 16'h1111};
    vecs[4]  = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h1111};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h2222};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h3333};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h4444};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 16'h00A5, 1'b0, 1'b1, 1'b1, 16'h00A5};
    vecs[11] = '{1'b1, 16'h005A, 1'b1, 1'b1, 1'b1, 16'h005A};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};

    // Reset, then idle
    rst = 1'b0;
    tick();
    check("rst_ready_low", 32'(host_in_ready), 32'd0);
    check("rst_avail", 32'(in_avail), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("idle_ready", 32'(host_in_ready), 32'd1);
    check("idle_avail", 32'(in_avail), 32'd0);
    check("idle_read_in", 32'(read_in), 32'd0);
    check("idle_out_valid", 32'(host_out_valid), 32'd0);
    check("idle_ovf", 32'(out_overflow), 32'd0);

    // Input FIFO fill/drain, empty ack, simultaneous push/pop
    for (int i = 0; i < 13; i++) begin
      host_in_valid = vecs[i].hv;
      host_in_data  = vecs[i].hd;
      in_ack        = vecs[i].ack;
      tick();
      check($sformatf("vec%0d_ready", i), 32'(host_in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_avail", i), 32'(in_avail), 32'(vecs[i].e_av));
      check($sformatf("vec%0d_read_in", i), 32'(read_in), 32'(vecs[i].e_rd));
    end
    host_in_valid = 1'b0;
    in_ack        = 1'b0;
    check("in_side_no_out", 32'(host_out_valid), 32'd0);

    // Output FIFO full with a simultaneous pop: the strobe is accepted
    host_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_strobe = 1'b1;
      write_out  = 16'h0010 + 16'(i);
      sb_q.push_back(write_out);
      tick();
    end
    out_strobe     = 1'b1;
    write_out      = 16'h0014;
    host_out_ready = 1'b1;
    sb_q.push_back(16'h0014);
    begin
      logic [WIDTH-1:0] exp;
      exp = sb_q.pop_front();
      check("fullpop_head", 32'(host_out_data), 32'(exp));
    end
    tick();
    out_strobe = 1'b0;
    check("fullpop_ovf", 32'(out_overflow), 32'd0);
    drain(20);
    check("fullpop_empty", 32'(host_out_valid), 32'd0);
    check("fullpop_ovf_end", 32'(out_overflow), 32'd0);

    // Output overflow: fifth strobe into a full FIFO is dropped
    host_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      out_strobe = 1'b1;
      write_out  = 16'(i);
      if (i <= 4) sb_q.push_back(write_out);
      tick();
    end
    out_strobe = 1'b0;
    check("ovf_set", 32'(out_overflow), 32'd1);
    check("ovf_head", 32'(host_out_data), 32'h0001);
    tick();
    check("ovf_hold_valid", 32'(host_out_valid), 32'd1);
    check("ovf_hold_data", 32'(host_out_data), 32'h0001);
    drain(20);
    check("ovf_empty", 32'(host_out_valid), 32'd0);
    check("ovf_sticky", 32'(out_overflow), 32'd1);

    // Reset in the middle of traffic with words buffered on both sides
    for (int i = 0; i < 2; i++) begin
      host_in_valid = 1'b1;
      host_in_data  = 16'h0BB1 + 16'(i);
      out_strobe    = 1'b1;
      write_out     = 16'h0CC1 + 16'(i);
      tick();
    end
    host_in_valid = 1'b0;
    out_strobe    = 1'b0;
    check("mid_avail", 32'(in_avail), 32'd1);
    check("mid_read_in", 32'(read_in), 32'h0BB1);
    check("mid_out_data", 32'(host_out_data), 32'h0CC1);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_ready", 32'(host_in_ready), 32'd0);
    check("mrst_avail", 32'(in_avail), 32'd0);
    check("mrst_read_in", 32'(read_in), 32'd0);
    check("mrst_out_valid", 32'(host_out_valid), 32'd0);
    check("mrst_out_data", 32'(host_out_data), 32'd0);
    check("mrst_ovf", 32'(out_overflow), 32'd0);
    sb_q.delete();
    @(posedge clock);
    #2;
    rst = 1'b1;
    #1;
    check("post_ready", 32'(host_in_ready), 32'd1);
    host_out_ready = 1'b1;
    in_ack         = 1'b1;
    tick();
    tick();
    check("post_avail", 32'(in_avail), 32'd0);
    check("post_read_in", 32'(read_in), 32'd0);
    check("post_out_valid", 32'(host_out_valid), 32'd0);
    in_ack         = 1'b0;
    host_out_ready = 1'b0;

    // Fresh traffic after reset
    host_in_valid = 1'b1;
    host_in_data  = 16'h0888;
    out_strobe    = 1'b1;
    write_out     = 16'h0777;
    sb_q.push_back(16'h0777);
    tick();
    host_in_valid = 1'b0;
    out_strobe    = 1'b0;
    check("fresh_read_in", 32'(read_in), 32'h0888);
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    check("fresh_in_empty", 32'(in_avail), 32'd0);
    drain(10);
    check("fresh_out_empty", 32'(host_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
